// File: rtl/fazyrv_rf_seq.sv
// Chunk sequencer for the shift-register register file: latches addresses per pass and strobes NCHUNKS shifts.
// Optional FAZYRV_RF_SEQ_DBG_EN adds dbg_res_o, which assembles the written result word.
module fazyrv_rf_seq #(
  parameter int unsigned CHUNKSIZE = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_in,
  input  logic                 start_i,
  input  logic                 wb_i,
  input  logic [4:0]           rs1_i,
  input  logic [4:0]           rs2_i,
  input  logic [4:0]           rd_i,
  input  logic                 stall_i,
  input  logic                 abort_i,
  input  logic [CHUNKSIZE-1:0] res_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 shft_o,
  output logic                 we_o,
  output logic [4:0]           rs1_o,
  output logic [4:0]           rs2_o,
  output logic [4:0]           rd_o,
  output logic [$clog2(32/CHUNKSIZE)-1:0] cnt_o,
  output logic                 first_o,
  output logic                 last_o
`ifdef FAZYRV_RF_SEQ_DBG_EN
  ,
  output logic [31:0]          dbg_res_o
`endif
);

  localparam int unsigned NCHUNKS = 32 / CHUNKSIZE;
  localparam int unsigned CW      = $clog2(NCHUNKS);
  localparam logic [CW-1:0] CNT_LAST = CW'(NCHUNKS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state;
  logic   wb_q;
  logic   run;
  logic   cnt_is_last;

  // Abort wins over both stall and the final shift.
  assign run         = (state == S_RUN);
  assign cnt_is_last = (cnt_o == CNT_LAST);
  assign shft_o      = run & ~stall_i & ~abort_i;
  assign we_o        = shft_o & wb_q & (rd_o != 5'd0);

  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      state   <= S_IDLE;
      cnt_o   <= '0;
      wb_q    <= 1'b0;
      rs1_o   <= 5'd0;
      rs2_o   <= 5'd0;
      rd_o    <= 5'd0;
      busy_o  <= 1'b0;
      done_o  <= 1'b0;
      first_o <= 1'b0;
      last_o  <= 1'b0;
    end else begin
      done_o <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start_i) begin
            rs1_o   <= rs1_i;
            rs2_o   <= rs2_i;
            rd_o    <= rd_i;
            wb_q    <= wb_i;
            cnt_o   <= '0;
            state   <= S_RUN;
            busy_o  <= 1'b1;
            first_o <= 1'b1;
            last_o  <= (NCHUNKS == 1);
          end
        end
        S_RUN: begin
          if (abort_i) begin
            state   <= S_IDLE;
            cnt_o   <= '0;
            busy_o  <= 1'b0;
            first_o <= 1'b0;
            last_o  <= 1'b0;
          end else if (shft_o) begin
            if (cnt_is_last) begin
              state   <= S_DONE;
              cnt_o   <= '0;
              done_o  <= 1'b1;
              first_o <= 1'b0;
              last_o  <= 1'b0;
            end else begin
              cnt_o   <= cnt_o + CW'(1);
              first_o <= 1'b0;
              last_o  <= ((cnt_o + CW'(1)) == CNT_LAST);
            end
          end
        end
        S_DONE: begin
          state  <= S_IDLE;
          busy_o <= 1'b0;
        end
        default: begin
          state   <= S_IDLE;
          busy_o  <= 1'b0;
          first_o <= 1'b0;
          last_o  <= 1'b0;
        end
      endcase
    end
  end

`ifdef FAZYRV_RF_SEQ_DBG_EN
  // Collects each written result chunk, least-significant chunk first.
  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      dbg_res_o <= 32'd0;
    end else if ((state == S_IDLE) && start_i) begin
      dbg_res_o <= 32'd0;
    end else if (we_o) begin
      dbg_res_o[CHUNKSIZE*32'(cnt_o) +: CHUNKSIZE] <= res_i;
    end
  end
`else
  logic unused_res;
  assign unused_res = ^res_i;
`endif

endmodule

// File: tb/tb_fazyrv_rf_seq.sv
// Randomized self-checking bench for fazyrv_rf_seq against a pass-level reference model.
module tb_fazyrv_rf_seq;

  localparam int unsigned CS  = 2;
  localparam int unsigned NCH = 32 / CS;
  localparam int unsigned CW  = $clog2(NCH);

  logic          clk;
  logic          rst_n;
  logic          start, wb, stall, abort;
  logic [4:0]    rs1, rs2, rd;
  logic [CS-1:0] res;
  logic          busy, done, shft, we, first, last;
  logic [4:0]    rs1_q, rs2_q, rd_q;
  logic [CW-1:0] cnt;
`ifdef FAZYRV_RF_SEQ_DBG_EN
  logic [31:0]   dbg_res;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  fazyrv_rf_seq #(.CHUNKSIZE(CS)) dut (
    .clk_i   (clk),
    .rst_in  (rst_n),
    .start_i (start),
    .wb_i    (wb),
    .rs1_i   (rs1),
    .rs2_i   (rs2),
    .rd_i    (rd),
    .stall_i (stall),
    .abort_i (abort),
    .res_i   (res),
    .busy_o  (busy),
    .done_o  (done),
    .shft_o  (shft),
    .we_o    (we),
    .rs1_o   (rs1_q),
    .rs2_o   (rs2_q),
    .rd_o    (rd_q),
    .cnt_o   (cnt),
    .first_o (first),
    .last_o  (last)
`ifdef FAZYRV_RF_SEQ_DBG_EN
    ,
    .dbg_res_o (dbg_res)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    start = 1'b0; wb = 1'b0; stall = 1'b0; abort = 1'b0;
    rs1 = 5'd0; rs2 = 5'd0; rd = 5'd0; res = '0;
  endtask

  // One register pass: directed stall window, optional abort, random stalls and ignored starts.
  task automatic run_pass(input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] ad,
                          input logic w, input int stall_pct, input int stall_at,
                          input int stall_len, input int abort_at, input logic chk_dbg);
    int          shifts    = 0;
    int          stalls    = 0;
    int          run_cyc   = 0;
    int          dir_stall = 0;
    int          n_we      = 0;
    bit          aborted   = 0;
    bit          finished  = 0;
    logic        e_shft, e_we;
    logic [31:0] e_dbg     = 32'd0;

    start = 1'b1; wb = w; rs1 = a1; rs2 = a2; rd = ad; stall = 1'b0; abort = 1'b0;
    #3;
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_shft", 32'(shft), 32'd0);
    next_cycle();

    for (int cyc = 0; cyc < 200 && !aborted && !finished; cyc++) begin
      start = ($urandom_range(0, 3) == 0);
      wb    = 1'($urandom);
      rs1   = 5'($urandom); rs2 = 5'($urandom); rd = 5'($urandom);
      res   = CS'($urandom);
      stall = ($urandom_range(0, 99) < stall_pct);
      if (shifts == stall_at && dir_stall < stall_len) begin
        stall = 1'b1;
        dir_stall++;
      end
      abort = (shifts == abort_at);
      e_shft = !stall && !abort;
      e_we   = e_shft && w && (ad != 5'd0);
      #3;
      check("run_busy",  32'(busy),  32'd1);
      check("run_done",  32'(done),  32'd0);
      check("run_cnt",   32'(cnt),   32'(shifts));
      check("run_first", 32'(first), 32'(shifts == 0));
      check("run_last",  32'(last),  32'(shifts == NCH - 1));
      check("run_shft",  32'(shft),  32'(e_shft));
      check("run_we",    32'(we),    32'(e_we));
      check("run_rs1",   32'(rs1_q), 32'(a1));
      check("run_rs2",   32'(rs2_q), 32'(a2));
      check("run_rd",    32'(rd_q),  32'(ad));
      if (e_we) begin
        e_dbg[shifts*CS +: CS] = res;
        n_we++;
      end
      run_cyc++;
      next_cycle();
      if (abort) aborted = 1;
      else if (e_shft) shifts++;
      else stalls++;
      if (shifts == NCH) finished = 1;
    end
    check("pass_timeout", 32'(aborted || finished), 32'd1);

    idle_inputs();
    if (aborted) begin
      #3;
      check("abort_busy", 32'(busy),  32'd0);
      check("abort_done", 32'(done),  32'd0);
      check("abort_shft", 32'(shft),  32'd0);
      check("abort_rd",   32'(rd_q),  32'(ad));
      next_cycle();
      #3;
      check("abort_nodone", 32'(done), 32'd0);
      next_cycle();
    end else if (finished) begin
      #3;
      check("done_pulse", 32'(done),  32'd1);
      check("done_busy",  32'(busy),  32'd1);
      check("done_first", 32'(first), 32'd0);
      check("done_last",  32'(last),  32'd0);
      check("done_shft",  32'(shft),  32'd0);
      check("run_len",    32'(run_cyc), 32'(NCH + stalls));
      check("we_count",   32'(n_we),  (w && ad != 5'd0) ? 32'(NCH) : 32'd0);
`ifdef FAZYRV_RF_SEQ_DBG_EN
      if (chk_dbg) check("dbg_res", dbg_res, e_dbg);
`else
      if (chk_dbg) check("dbg_model_empty", e_dbg & 32'd0, 32'd0);
`endif
      next_cycle();
      #3;
      check("post_busy", 32'(busy), 32'd0);
      check("post_done", 32'(done), 32'd0);
      next_cycle();
    end
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    #3;
    check("rst_busy",  32'(busy),  32'd0);
    check("rst_done",  32'(done),  32'd0);
    check("rst_shft",  32'(shft),  32'd0);
    check("rst_we",    32'(we),    32'd0);
    check("rst_first", 32'(first), 32'd0);
    check("rst_last",  32'(last),  32'd0);
    check("rst_cnt",   32'(cnt),   32'd0);
    check("rst_addr",  32'({rs1_q, rs2_q, rd_q}), 32'd0);
    #9 rst_n = 1'b1;
    next_cycle();

    // Directed: plain pass, x0 destination, stall window, abort.
    run_pass(5'd3, 5'd5, 5'd7, 1'b1, 0, -1, 0, -1, 1'b1);
    run_pass(5'd3, 5'd5, 5'd0, 1'b1, 0, -1, 0, -1, 1'b1);
    run_pass(5'd3, 5'd5, 5'd7, 1'b1, 0, 4, 3, -1, 1'b1);
    run_pass(5'd3, 5'd5, 5'd7, 1'b1, 0, -1, 0, 9, 1'b0);
    run_pass(5'd1, 5'd2, 5'd31, 1'b0, 0, NCH - 1, 2, -1, 1'b1);

    // Asynchronous reset mid-pass, checked without a clock edge.
    start = 1'b1; wb = 1'b1; rs1 = 5'd9; rs2 = 5'd10; rd = 5'd11;
    next_cycle();
    idle_inputs();
    for (int i = 0; i < 6; i++) next_cycle();
    #2;
    check("mid_cnt", 32'(cnt), 32'd6);
    rst_n = 1'b0;
    #1;
    check("arst_busy",  32'(busy),  32'd0);
    check("arst_shft",  32'(shft),  32'd0);
    check("arst_we",    32'(we),    32'd0);
    check("arst_first", 32'(first), 32'd0);
    check("arst_last",  32'(last),  32'd0);
    check("arst_cnt",   32'(cnt),   32'd0);
    check("arst_rd",    32'(rd_q),  32'd0);
    next_cycle();
    #2 rst_n = 1'b1;
    next_cycle();
    run_pass(5'd9, 5'd10, 5'd11, 1'b1, 0, -1, 0, -1, 1'b1);

    // Randomized passes.
    for (int p = 0; p < 40; p++) begin
      logic [4:0] ad;
      int         ab;
      ad = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom);
      ab = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, NCH - 1)) : -1;
      run_pass(5'($urandom), 5'($urandom), ad, 1'($urandom), int'($urandom_range(0, 40)),
               int'($urandom_range(0, NCH - 1)), int'($urandom_range(0, 3)), ab, 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
